// File: rtl/exe_maint_arbiter.sv
// Serialises execute-stage TLB/cache maintenance requests onto one downstream req/ack/done port.
// Optional watchdog on outstanding operations is enabled by defining EXE_MAINT_WATCHDOG_EN.
module exe_maint_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_exe_reset,
  input  logic              i_tlbcheck_do,
  input  logic [ADDR_W-1:0] i_tlbcheck_address,
  input  logic              i_tlbcheck_rw,
  output logic              o_tlbcheck_done,
  output logic              o_tlbcheck_page_fault,
  input  logic              i_tlbflushsingle_do,
  input  logic [ADDR_W-1:0] i_tlbflushsingle_address,
  output logic              o_tlbflushsingle_done,
  input  logic              i_invdcode_do,
  output logic              o_invdcode_done,
  input  logic              i_invddata_do,
  output logic              o_invddata_done,
  input  logic              i_wbinvddata_do,
  output logic              o_wbinvddata_done,
  output logic              o_maint_req,
  output logic [2:0]        o_maint_op,
  output logic [ADDR_W-1:0] o_maint_address,
  output logic              o_maint_rw,
  input  logic              i_maint_ack,
  input  logic              i_maint_done,
  input  logic              i_maint_fault,
`ifdef EXE_MAINT_WATCHDOG_EN
  output logic              o_maint_timeout,
`endif
  output logic              o_maint_busy
);

  localparam logic [2:0] OpTlbCheck   = 3'd0;
  localparam logic [2:0] OpTlbFlush   = 3'd1;
  localparam logic [2:0] OpInvdCode   = 3'd2;
  localparam logic [2:0] OpInvdData   = 3'd3;
  localparam logic [2:0] OpWbinvdData = 3'd4;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [2:0]          r_op, w_op_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic                r_rw, w_rw_next;
  logic [4:0]          r_done, w_done_next;
  logic                r_pf, w_pf_next;
  logic                w_wd_expired;

`ifdef EXE_MAINT_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  logic [CntW-1:0] r_wd_cnt;
  logic            r_timeout;

  assign w_wd_expired = (r_wd_cnt == CntW'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change, so entry to WAIT/DRAIN always begins at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_state_next != r_state) begin
        r_wd_cnt <= '0;
      end else if (r_state == StWait || r_state == StDrain) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if ((r_state == StWait || r_state == StDrain) && w_wd_expired &&
          w_state_next == StDone) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_maint_timeout = r_timeout;
`else
  assign w_wd_expired = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_addr_next  = r_addr;
    w_rw_next    = r_rw;
    w_done_next  = '0;
    w_pf_next    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!i_exe_reset) begin
          w_state_next = StReq;
          if (i_tlbcheck_do) begin
            w_op_next   = OpTlbCheck;
            w_addr_next = i_tlbcheck_address;
            w_rw_next   = i_tlbcheck_rw;
          end else if (i_tlbflushsingle_do) begin
            w_op_next   = OpTlbFlush;
            w_addr_next = i_tlbflushsingle_address;
            w_rw_next   = 1'b0;
          end else if (i_wbinvddata_do) begin
            w_op_next   = OpWbinvdData;
            w_addr_next = '0;
            w_rw_next   = 1'b0;
          end else if (i_invddata_do) begin
            w_op_next   = OpInvdData;
            w_addr_next = '0;
            w_rw_next   = 1'b0;
          end else if (i_invdcode_do) begin
            w_op_next   = OpInvdCode;
            w_addr_next = '0;
            w_rw_next   = 1'b0;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      StReq: begin
        if (i_maint_ack) begin
          if (i_exe_reset) begin
            // An accepted-and-finished op under flush has nothing left to drain.
            w_state_next = i_maint_done ? StIdle : StDrain;
          end else if (i_maint_done) begin
            w_state_next = StDone;
            w_done_next  = 5'b00001 << r_op;
            w_pf_next    = (r_op == OpTlbCheck) && i_maint_fault;
          end else begin
            w_state_next = StWait;
          end
        end else if (i_exe_reset) begin
          w_state_next = StIdle;
        end
      end
      StWait: begin
        if (i_exe_reset) begin
          w_state_next = i_maint_done ? StIdle : StDrain;
        end else if (i_maint_done) begin
          w_state_next = StDone;
          w_done_next  = 5'b00001 << r_op;
          w_pf_next    = (r_op == OpTlbCheck) && i_maint_fault;
        end else if (w_wd_expired) begin
          w_state_next = StDone;
          w_done_next  = 5'b00001 << r_op;
          w_pf_next    = (r_op == OpTlbCheck);
        end
      end
      StDrain: begin
        if (i_maint_done) begin
          w_state_next = StIdle;
        end else if (w_wd_expired) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_op    <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_done  <= '0;
      r_pf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_addr  <= w_addr_next;
      r_rw    <= w_rw_next;
      r_done  <= w_done_next;
      r_pf    <= w_pf_next;
    end
  end

  assign o_maint_req           = (r_state == StReq);
  assign o_maint_busy          = (r_state != StIdle);
  assign o_maint_op            = r_op;
  assign o_maint_address       = r_addr;
  assign o_maint_rw            = r_rw;
  assign o_tlbcheck_done       = r_done[OpTlbCheck];
  assign o_tlbflushsingle_done = r_done[OpTlbFlush];
  assign o_invdcode_done       = r_done[OpInvdCode];
  assign o_invddata_done       = r_done[OpInvdData];
  assign o_wbinvddata_done     = r_done[OpWbinvdData];
  assign o_tlbcheck_page_fault = r_pf;

endmodule

// File: tb/tb_exe_maint_arbiter.sv
// Scoreboard bench for exe_maint_arbiter: expected requests and done pulses are queued as
// stimulus is applied and compared when the DUT presents them.
module tb_exe_maint_arbiter;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          exe_reset;
  logic          tlbcheck_do, tlbcheck_rw, tlbcheck_done, tlbcheck_page_fault;
  logic [AW-1:0] tlbcheck_address, tlbflushsingle_address, maint_address;
  logic          tlbflushsingle_do, tlbflushsingle_done;
  logic          invdcode_do, invdcode_done, invddata_do, invddata_done;
  logic          wbinvddata_do, wbinvddata_done;
  logic          maint_req, maint_rw, maint_ack, maint_done, maint_fault, maint_busy;
  logic [2:0]    maint_op;
`ifdef EXE_MAINT_WATCHDOG_EN
  logic          maint_timeout;
`endif
  logic [4:0]    done_vec;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic          rw;
  } req_t;

  typedef struct {
    logic [4:0] vec;
    logic       pf;
  } done_t;

  req_t  exp_req_q[$];
  done_t exp_done_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  assign done_vec = {wbinvddata_done, invddata_done, invdcode_done, tlbflushsingle_done,
                     tlbcheck_done};

  exe_maint_arbiter #(
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_exe_reset             (exe_reset),
    .i_tlbcheck_do           (tlbcheck_do),
    .i_tlbcheck_address      (tlbcheck_address),
    .i_tlbcheck_rw           (tlbcheck_rw),
    .o_tlbcheck_done         (tlbcheck_done),
    .o_tlbcheck_page_fault   (tlbcheck_page_fault),
    .i_tlbflushsingle_do     (tlbflushsingle_do),
    .i_tlbflushsingle_address(tlbflushsingle_address),
    .o_tlbflushsingle_done   (tlbflushsingle_done),
    .i_invdcode_do           (invdcode_do),
    .o_invdcode_done         (invdcode_done),
    .i_invddata_do           (invddata_do),
    .o_invddata_done         (invddata_done),
    .i_wbinvddata_do         (wbinvddata_do),
    .o_wbinvddata_done       (wbinvddata_done),
    .o_maint_req             (maint_req),
    .o_maint_op              (maint_op),
    .o_maint_address         (maint_address),
    .o_maint_rw              (maint_rw),
    .i_maint_ack             (maint_ack),
    .i_maint_done            (maint_done),
    .i_maint_fault           (maint_fault),
`ifdef EXE_MAINT_WATCHDOG_EN
    .o_maint_timeout         (maint_timeout),
`endif
    .o_maint_busy            (maint_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [2:0] op, input logic [AW-1:0] addr, input logic rw);
    req_t r;
    r.op   = op;
    r.addr = addr;
    r.rw   = rw;
    exp_req_q.push_back(r);
  endtask

  task automatic push_done(input logic [4:0] vec, input logic pf);
    done_t d;
    d.vec = vec;
    d.pf  = pf;
    exp_done_q.push_back(d);
  endtask

  // max_wait = 0 demands the request in the current cycle.
  task automatic expect_req(input string tag, input int max_wait);
    req_t e;
    int   n = 0;
    while (!maint_req && n < max_wait) begin
      tick();
      n++;
    end
    check_eq({tag, "_req"}, maint_req, 1);
    check_eq({tag, "_sb_nonempty"}, exp_req_q.size() != 0, 1);
    if (exp_req_q.size() != 0) begin
      e = exp_req_q.pop_front();
      check_eq({tag, "_op"}, maint_op, e.op);
      check_eq({tag, "_addr"}, maint_address, e.addr);
      check_eq({tag, "_rw"}, maint_rw, e.rw);
    end
  endtask

  task automatic expect_done(input string tag);
    done_t e;
    check_eq({tag, "_dsb_nonempty"}, exp_done_q.size() != 0, 1);
    if (exp_done_q.size() != 0) begin
      e = exp_done_q.pop_front();
      check_eq({tag, "_done"}, done_vec, e.vec);
      check_eq({tag, "_pf"}, tlbcheck_page_fault, e.pf);
    end
  endtask

  task automatic expect_quiet(input string tag);
    check_eq({tag, "_no_done"}, done_vec, 0);
    check_eq({tag, "_no_pf"}, tlbcheck_page_fault, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL tb_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; exe_reset = 1'b0;
    tlbcheck_do = 1'b0; tlbcheck_rw = 1'b0; tlbcheck_address = '0;
    tlbflushsingle_do = 1'b0; tlbflushsingle_address = '0;
    invdcode_do = 1'b0; invddata_do = 1'b0; wbinvddata_do = 1'b0;
    maint_ack = 1'b0; maint_done = 1'b0; maint_fault = 1'b0;
    tick();
    tick();
    check_eq("rst_req", maint_req, 0);
    check_eq("rst_busy", maint_busy, 0);
    check_eq("rst_op", maint_op, 0);
    check_eq("rst_addr", maint_address, 0);
    check_eq("rst_rw", maint_rw, 0);
    expect_quiet("rst");
`ifdef EXE_MAINT_WATCHDOG_EN
    check_eq("rst_timeout", maint_timeout, 0);
`endif
    rst_n = 1'b1;
    tick();

    // tlbcheck with fault: ack one cycle after req, done two cycles later
    tlbcheck_do = 1'b1; tlbcheck_address = 32'h0040_1000; tlbcheck_rw = 1'b1;
    push_req(3'd0, 32'h0040_1000, 1'b1);
    tick();
    expect_req("chk", 0);
    tlbcheck_do = 1'b0; maint_ack = 1'b1;
    tick();
    maint_ack = 1'b0;
    check_eq("chk_req_drop", maint_req, 0);
    check_eq("chk_busy_wait", maint_busy, 1);
    tick();
    maint_done = 1'b1; maint_fault = 1'b1;
    push_done(5'b00001, 1'b1);
    tick();
    maint_done = 1'b0; maint_fault = 1'b0;
    expect_done("chk");
    check_eq("chk_addr_hold", maint_address, 32'h0040_1000);
    tick();
    expect_quiet("chk_one_cycle");
    check_eq("chk_idle", maint_busy, 0);

    // simultaneous flush + invdcode: flush wins, invdcode follows after the flush completes
    tlbflushsingle_do = 1'b1; tlbflushsingle_address = 32'h0000_1000; invdcode_do = 1'b1;
    push_req(3'd1, 32'h0000_1000, 1'b0);
    push_req(3'd2, 32'h0, 1'b0);
    tick();
    expect_req("flush", 0);
    tlbflushsingle_do = 1'b0; maint_ack = 1'b1;
    tick();
    maint_ack = 1'b0; maint_done = 1'b1;
    push_done(5'b00010, 1'b0);
    tick();
    maint_done = 1'b0;
    expect_done("flush");
    check_eq("flush_done_noreq", maint_req, 0);
    tick();
    check_eq("invdc_not_early", maint_req, 0);
    tick();
    expect_req("invdc", 0);
    invdcode_do = 1'b0; maint_ack = 1'b1; maint_done = 1'b1; maint_fault = 1'b1;
    push_done(5'b00100, 1'b0);
    tick();
    maint_ack = 1'b0; maint_done = 1'b0; maint_fault = 1'b0;
    expect_done("invdc");
    tick();
    expect_quiet("invdc_one_cycle");

    // wbinvd with ack+done together; level still held through DONE must not re-issue
    wbinvddata_do = 1'b1;
    push_req(3'd4, 32'h0, 1'b0);
    tick();
    expect_req("wbinvd", 0);
    maint_ack = 1'b1; maint_done = 1'b1;
    push_done(5'b10000, 1'b0);
    tick();
    maint_ack = 1'b0; maint_done = 1'b0;
    expect_done("wbinvd");
    check_eq("wbinvd_done_noreq", maint_req, 0);
    tick();
    check_eq("wbinvd_idle_noreq", maint_req, 0);
    expect_quiet("wbinvd_one_cycle");
    wbinvddata_do = 1'b0;
    tick();
    check_eq("wbinvd_no_second", maint_req, 0);

    // exe_reset in REQ before ack aborts silently
    invddata_do = 1'b1;
    push_req(3'd3, 32'h0, 1'b0);
    tick();
    expect_req("invdd", 0);
    invddata_do = 1'b0; exe_reset = 1'b1;
    tick();
    exe_reset = 1'b0;
    check_eq("abort_req", maint_req, 0);
    check_eq("abort_busy", maint_busy, 0);
    expect_quiet("abort");
    tick();
    expect_quiet("abort_next");

    // exe_reset in IDLE blocks the grant for that cycle
    invdcode_do = 1'b1; exe_reset = 1'b1;
    tick();
    check_eq("blk_req", maint_req, 0);
    check_eq("blk_busy", maint_busy, 0);
    exe_reset = 1'b0;
    push_req(3'd2, 32'h0, 1'b0);
    tick();
    expect_req("blk_then", 0);
    invdcode_do = 1'b0; maint_ack = 1'b1;
    tick();
    maint_ack = 1'b0; exe_reset = 1'b1;
    tick();
    exe_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("drain_busy", maint_busy, 1);
      expect_quiet("drain_wait");
      tick();
    end
    maint_done = 1'b1; maint_fault = 1'b1;
    tick();
    maint_done = 1'b0; maint_fault = 1'b0;
    expect_quiet("drain_swallow");
    check_eq("drain_idle", maint_busy, 0);

    // asynchronous reset in the middle of WAIT
    tlbflushsingle_do = 1'b1; tlbflushsingle_address = 32'hdead_b000;
    push_req(3'd1, 32'hdead_b000, 1'b0);
    tick();
    expect_req("arst", 0);
    tlbflushsingle_do = 1'b0; maint_ack = 1'b1;
    tick();
    maint_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req", maint_req, 0);
    check_eq("arst_busy", maint_busy, 0);
    check_eq("arst_op", maint_op, 0);
    check_eq("arst_addr", maint_address, 0);
    expect_quiet("arst");
    #1 rst_n = 1'b1;
    tick();
    maint_done = 1'b1;
    tick();
    maint_done = 1'b0;
    expect_quiet("arst_late_done");
    check_eq("arst_late_busy", maint_busy, 0);
    check_eq("arst_late_req", maint_req, 0);

`ifdef EXE_MAINT_WATCHDOG_EN
    // watchdog: acked tlbcheck never completes
    tlbcheck_do = 1'b1; tlbcheck_address = 32'h0000_2000; tlbcheck_rw = 1'b0;
    push_req(3'd0, 32'h0000_2000, 1'b0);
    tick();
    expect_req("wd", 0);
    tlbcheck_do = 1'b0; maint_ack = 1'b1;
    tick();
    maint_ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_eq("wd_pending_done", tlbcheck_done, 0);
      check_eq("wd_pending_flag", maint_timeout, 0);
      tick();
    end
    check_eq("wd_last_wait_flag", maint_timeout, 0);
    push_done(5'b00001, 1'b1);
    tick();
    expect_done("wd");
    check_eq("wd_flag", maint_timeout, 1);
    tick();
    expect_quiet("wd_one_cycle");
    check_eq("wd_sticky", maint_timeout, 1);
    tick();
    check_eq("wd_sticky2", maint_timeout, 1);
    check_eq("wd_idle", maint_busy, 0);
`endif

    check_eq("sb_req_drained", exp_req_q.size(), 0);
    check_eq("sb_done_drained", exp_done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exe_maint_arbiter.md
Name: exe_maint_arbiter

Overview:
- Arbitrates and sequences execute-stage maintenance requests onto one shared downstream maintenance port toward the TLB/cache subsystem.
- Requests covered: tlbcheck, tlbflushsingle, invdcode, invddata, wbinvddata.
- Sits between the execute command logic and the memory subsystem. Guarantees that only one maintenance operation is outstanding at a time.
- Converts the held-level "do" / one-cycle "done" protocol of each requester into a req/ack/done transaction.

Parameters:
- ADDR_W, 32, width of the tlbcheck/tlbflushsingle address path.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with EXE_MAINT_WATCHDOG_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exe_reset  in  1  pipeline flush; aborts or drains the current operation.
- tlbcheck_do  in  1  tlbcheck request level.
- tlbcheck_address  in  ADDR_W  address to check.
- tlbcheck_rw  in  1  1 = write check.
- tlbcheck_done  out  1  completion pulse.
- tlbcheck_page_fault  out  1  valid with tlbcheck_done.
- tlbflushsingle_do  in  1  single-page flush request.
- tlbflushsingle_address  in  ADDR_W  page address to flush.
- tlbflushsingle_done  out  1  completion pulse.
- invdcode_do  in  1  request.
- invdcode_done  out  1  pulse.
- invddata_do  in  1  request.
- invddata_done  out  1  pulse.
- wbinvddata_do  in  1  request.
- wbinvddata_done  out  1  pulse.
- maint_req  out  1  downstream request, held until maint_ack.
- maint_op  out  3  0 tlbcheck, 1 tlbflushsingle, 2 invdcode, 3 invddata, 4 wbinvddata.
- maint_address  out  ADDR_W  latched address; 0 for invd/wbinvd ops.
- maint_rw  out  1  latched tlbcheck_rw; 0 for all other ops.
- maint_ack  in  1  downstream accepted request.
- maint_done  in  1  downstream completion pulse.
- maint_fault  in  1  page fault, valid with maint_done.
- maint_busy  out  1  state != IDLE.
- maint_timeout  out  1  sticky watchdog flag; present only with EXE_MAINT_WATCHDOG_EN.

Behaviour:
- Reset: all outputs 0; state IDLE; latched op/address/rw 0.
- States and transitions:
  - IDLE: if any do is asserted and exe_reset = 0, grant by fixed priority: tlbcheck > tlbflushsingle > wbinvddata > invddata > invdcode. Latch op, address and rw, then go to REQ.
  - REQ: maint_req = 1.
    - maint_ack = 1 and maint_done = 0 -> WAIT.
    - maint_ack = 1 and maint_done = 1 in the same cycle -> completion handled as in WAIT.
    - exe_reset = 1 without ack -> IDLE, with no done pulse.
  - WAIT: on maint_done, pulse the granted requester's done for exactly 1 cycle in the following cycle. tlbcheck_page_fault = maint_fault for that cycle (tlbcheck only, else 0). Then go to DONE.
    - exe_reset = 1 while in WAIT, or in REQ together with ack -> DRAIN.
  - DRAIN: wait for maint_done, swallow it (no done pulse, no fault), then go to IDLE.
  - DONE: 1 cycle; all do inputs ignored so the requester can drop its level; then go to IDLE.
- Latency:
  - do seen in IDLE at cycle N -> maint_req high at N+1.
  - maint_done at cycle M -> requester done at M+1.
  - Earliest new grant at M+2.
- Outputs are registered; maint_op, maint_address and maint_rw are stable from REQ until the return to IDLE.
- Requests that arrive simultaneously: the loser keeps its do level held and is granted on a later IDLE.
- A do dropped by its requester before the grant is never issued. A do dropped after the grant does not abort the operation; only exe_reset aborts.
- exe_reset asserted in IDLE blocks grants for that cycle.
- maint_done outside WAIT/REQ/DRAIN is ignored.

Optional Feature:
- Macro: EXE_MAINT_WATCHDOG_EN.
- With the macro defined:
  - A counter clears on entry to WAIT/DRAIN and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES-1 without maint_done, maint_timeout is set (sticky until rst_n) and the state goes to DONE.
  - From WAIT, the requester done is pulsed, with tlbcheck_page_fault = 1 if the op was tlbcheck. From DRAIN, no pulse.
- Without the macro: no counter, no maint_timeout port, WAIT/DRAIN wait indefinitely.

Test Plan:
- tlbcheck_do = 1, address 0x0040_1000, rw = 1; ack at +1; done with fault = 1 at +3 -> maint_op = 0, maint_address = 0x0040_1000, maint_rw = 1; tlbcheck_done and tlbcheck_page_fault high for exactly 1 cycle.
- invdcode_do and tlbflushsingle_do (address 0x1000) asserted in the same cycle -> flush issued first (op = 1, address 0x1000); invdcode issued (op = 2, address 0) no earlier than 2 cycles after the flush's maint_done.
- wbinvddata_do, ack and done in the same cycle -> wbinvddata_done exactly 1 cycle; do still held during DONE -> no second maint_req.
- exe_reset in REQ before ack -> IDLE, maint_req drops, no done pulse. exe_reset in WAIT -> done from downstream swallowed, maint_busy stays 1 until that maint_done arrives.
- rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously; a later maint_done is ignored.
- With EXE_MAINT_WATCHDOG_EN and TIMEOUT_CYCLES = 8: tlbcheck acked, no done -> after 8 WAIT cycles maint_timeout = 1 (stays 1), tlbcheck_done = 1 with page_fault = 1.
